// File: rtl/signed_alu_sched.sv
// -----------------------------------------------------------------------------
// signed_alu_sched
//
// Round-robin scheduler sharing one signed W-bit ALU (add, sub, mul, gt, eq)
// among NREQ requesters. One operation is in flight at a time; the result is
// returned tagged with the owning requester index together with a signed
// overflow flag (add/sub) and an illegal-opcode flag.
//
// Parameters
//    W        operand width, two's complement
//    NREQ     number of requesters (2..8)
//    MUL_LAT  EXEC cycles spent on a multiply (>=1); every other op takes 1
//
// Ports
//    clk          rising-edge clock
//    rst_n        asynchronous active-low reset
//    req_valid    [NREQ]       per-requester request valid
//    req_ready    [NREQ]       one-hot accept strobe (combinational, IDLE only)
//    req_op       [3*NREQ]     per-requester opcode: 0 add, 1 sub, 2 mul,
//                              3 gt, 4 eq, 5..7 illegal
//    req_a        [W*NREQ]     per-requester operand a
//    req_b        [W*NREQ]     per-requester operand b
//    rsp_valid    result valid
//    rsp_ready    consumer accepts result
//    rsp_id       [$clog2(NREQ)] owner of the result
//    rsp_result   [2*W]        signed result
//    rsp_ovf      signed overflow (add/sub only)
//    rsp_err      illegal opcode
//    busy         high whenever an operation is in flight
//
// Build option
//    SIGNED_ALU_SAT_EN  when defined, add/sub clamp to the most positive or
//                       most negative W-bit value on overflow (rsp_ovf still
//                       reports 1). When undefined, add/sub wrap modulo 2^W.
//
// States
//    state | meaning
//    IDLE  | waiting for a request; grants the next valid requester
//    EXEC  | operation executing, cnt_q counts down the remaining cycles
//    RESP  | result presented, held until rsp_valid & rsp_ready
// -----------------------------------------------------------------------------
module signed_alu_sched #(
    parameter int W       = 8,
    parameter int NREQ    = 3,
    parameter int MUL_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [3*NREQ-1:0]         req_op,
    input  logic [W*NREQ-1:0]         req_a,
    input  logic [W*NREQ-1:0]         req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*W-1:0]            rsp_result,
    output logic                      rsp_ovf,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_GT  = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [2:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] cnt_q;

    logic             load_grant;
    logic             load_result;

    // -------------------------------------------------------------------------
    // Unpack the flat request buses
    // -------------------------------------------------------------------------
    logic [2:0]   op_arr [NREQ];
    logic [W-1:0] a_arr  [NREQ];
    logic [W-1:0] b_arr  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i] = req_op[i*3 +: 3];
            a_arr[i]  = req_a[i*W +: W];
            b_arr[i]  = req_b[i*W +: W];
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first valid index at or after rr_ptr, with wrap.
    // The scan runs from the farthest offset down to offset 0 so the closest
    // valid requester is the last one written and therefore wins.
    // -------------------------------------------------------------------------
    logic            any_valid;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   scan_idx;

    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NREQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NREQ);
            end
            if (req_valid[scan_idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                grant_idx = scan_idx[ID_W-1:0];
            end
        end
    end

    assign rr_ptr_nxt = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        load_grant  = 1'b0;
        load_result = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    req_ready[grant_idx] = 1'b1;
                    load_grant           = 1'b1;
                    state_nxt            = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    load_result = 1'b1;
                    state_nxt   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // ALU on the captured operands
    // -------------------------------------------------------------------------
    logic [W-1:0]          sum_w;
    logic [W-1:0]          diff_w;
    logic                  ovf_add;
    logic                  ovf_sub;
    logic [W-1:0]          add_w;
    logic [W-1:0]          sub_w;
    logic signed [2*W-1:0] a_ext;
    logic signed [2*W-1:0] b_ext;
    logic signed [2*W-1:0] prod;
    logic [2*W-1:0]        alu_res;
    logic                  alu_ovf;
    logic                  alu_err;

    always_comb begin
        sum_w   = a_q + b_q;
        diff_w  = a_q - b_q;
        // Overflow is only possible when the true result's sign is forced by
        // the operands; it shows up as the wrapped sign disagreeing with a.
        ovf_add = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1]  != a_q[W-1]);
        ovf_sub = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
`ifdef SIGNED_ALU_SAT_EN
        // On overflow the true result always carries a's sign.
        add_w   = ovf_add ? (a_q[W-1] ? SAT_MIN : SAT_MAX) : sum_w;
        sub_w   = ovf_sub ? (a_q[W-1] ? SAT_MIN : SAT_MAX) : diff_w;
`else
        add_w   = sum_w;
        sub_w   = diff_w;
`endif
        a_ext   = {{W{a_q[W-1]}}, a_q};
        b_ext   = {{W{b_q[W-1]}}, b_q};
        prod    = a_ext * b_ext;

        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = {{W{add_w[W-1]}}, add_w};
                alu_ovf = ovf_add;
            end
            OP_SUB: begin
                alu_res = {{W{sub_w[W-1]}}, sub_w};
                alu_ovf = ovf_sub;
            end
            OP_MUL: begin
                alu_res = prod;
            end
            OP_GT: begin
                alu_res = {{(2*W-1){1'b0}}, ($signed(a_q) > $signed(b_q))};
            end
            OP_EQ: begin
                alu_res = {{(2*W-1){1'b0}}, (a_q == b_q)};
            end
            default: begin
                alu_err = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand capture, cycle counter and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (load_grant) begin
                op_q   <= op_arr[grant_idx];
                a_q    <= a_arr[grant_idx];
                b_q    <= b_arr[grant_idx];
                id_q   <= grant_idx;
                cnt_q  <= (op_arr[grant_idx] == OP_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(1);
                rr_ptr <= rr_ptr_nxt;
            end else if ((state == ST_EXEC) && (cnt_q != CNT_W'(1))) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (load_result) begin
                rsp_id     <= id_q;
                rsp_result <= alu_res;
                rsp_ovf    <= alu_ovf;
                rsp_err    <= alu_err;
            end
        end
    end

endmodule

// File: tb/tb_signed_alu_sched.sv
module tb_signed_alu_sched;

    localparam int W       = 8;
    localparam int NREQ    = 3;
    localparam int MUL_LAT = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_GT  = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;

`ifdef SIGNED_ALU_SAT_EN
    localparam logic [15:0] EXP_POS_OVF = 16'h007F;
    localparam logic [15:0] EXP_NEG_OVF = 16'hFF80;
`else
    localparam logic [15:0] EXP_POS_OVF = 16'hFF80;
    localparam logic [15:0] EXP_NEG_OVF = 16'h007F;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_op;
    logic [W*NREQ-1:0]    req_a;
    logic [W*NREQ-1:0]    req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [2*W-1:0]       rsp_result;
    logic                 rsp_ovf;
    logic                 rsp_err;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    signed_alu_sched #(.W(W), .NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int idx, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[idx*3 +: 3] = op;
        req_a[idx*8 +: 8]  = a;
        req_b[idx*8 +: 8]  = b;
    endtask

    task automatic apply_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request, scrambles its operands after the grant, and reports
    // what the DUT did: ready vector at grant, cycles to rsp_valid, response.
    task automatic run_op(input int idx, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          output logic [2:0] rdy, output int lat,
                          output logic [15:0] res, output logic ovf,
                          output logic err, output logic [1:0] id,
                          output logic busy_all);
        @(negedge clk);
        set_req(idx, op, a, b);
        req_valid[idx] = 1'b1;
        rsp_ready      = 1'b1;
        #1;
        rdy = req_ready;
        @(negedge clk);
        req_valid[idx] = 1'b0;
        set_req(idx, 3'd7, ~a, ~b);
        lat      = 1;
        busy_all = busy;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            busy_all = busy_all & busy;
        end
        res = rsp_result;
        ovf = rsp_ovf;
        err = rsp_err;
        id  = rsp_id;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b, want 0/0/0",
                     req_ready, rsp_valid, busy);
        end
        n_checks++;
        if ({rsp_id, rsp_result, rsp_ovf, rsp_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got id=%0d res=%h ovf=%b err=%b, want all 0",
                     rsp_id, rsp_result, rsp_ovf, rsp_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rsp_valid, busy} !== 2'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got valid=%b busy=%b, want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_add_ovf;
        logic [2:0] rdy; int lat; logic [15:0] res; logic ovf, err, ba; logic [1:0] id;
        run_op(0, OP_ADD, 8'h7F, 8'h01, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (rdy !== 3'b001) begin
            n_fail++; $display("FAIL add_grant: got %b, want 001", rdy);
        end
        n_checks++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL add_latency: got %0d, want 2", lat);
        end
        n_checks++;
        if ({res, ovf, err, id} !== {EXP_POS_OVF, 1'b1, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL add_7f_01: got res=%h ovf=%b err=%b id=%0d, want %h 1 0 0",
                     res, ovf, err, id, EXP_POS_OVF);
        end
    endtask

    task automatic test_sub_ovf;
        logic [2:0] rdy; int lat; logic [15:0] res; logic ovf, err, ba; logic [1:0] id;
        run_op(1, OP_SUB, 8'h80, 8'h01, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({rdy, res, ovf, id} !== {3'b010, EXP_NEG_OVF, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL sub_80_01: got rdy=%b res=%h ovf=%b id=%0d, want 010 %h 1 1",
                     rdy, res, ovf, id, EXP_NEG_OVF);
        end
        // Lone requester is granted again even though rr_ptr moved past it.
        run_op(1, OP_ADD, 8'h80, 8'hFF, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({rdy, res, ovf, id} !== {3'b010, EXP_NEG_OVF, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL add_80_ff: got rdy=%b res=%h ovf=%b id=%0d, want 010 %h 1 1",
                     rdy, res, ovf, id, EXP_NEG_OVF);
        end
        run_op(1, OP_SUB, 8'h05, 8'h03, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({res, ovf, err} !== {16'h0002, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_05_03: got res=%h ovf=%b err=%b, want 0002 0 0", res, ovf, err);
        end
        run_op(1, OP_ADD, 8'hFE, 8'hFD, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({res, ovf} !== {16'hFFFB, 1'b0}) begin
            n_fail++;
            $display("FAIL add_fe_fd: got res=%h ovf=%b, want fffb 0", res, ovf);
        end
    endtask

    task automatic test_mul;
        logic [2:0] rdy; int lat; logic [15:0] res; logic ovf, err, ba; logic [1:0] id;
        run_op(2, OP_MUL, 8'h40, 8'h40, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (rdy !== 3'b100) begin
            n_fail++; $display("FAIL mul_grant: got %b, want 100", rdy);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++; $display("FAIL mul_latency: got %0d, want 4", lat);
        end
        n_checks++;
        if (ba !== 1'b1) begin
            n_fail++; $display("FAIL mul_busy: busy dropped during mul, got %b want 1", ba);
        end
        n_checks++;
        if ({res, ovf, err, id} !== {16'h1000, 1'b0, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL mul_40_40: got res=%h ovf=%b err=%b id=%0d, want 1000 0 0 2",
                     res, ovf, err, id);
        end
        run_op(0, OP_MUL, 8'h80, 8'h80, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (res !== 16'h4000) begin
            n_fail++; $display("FAIL mul_80_80: got %h, want 4000", res);
        end
        run_op(0, OP_MUL, 8'hFF, 8'h02, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (res !== 16'hFFFE) begin
            n_fail++; $display("FAIL mul_ff_02: got %h, want fffe", res);
        end
    endtask

    task automatic test_compare;
        logic [2:0] rdy; int lat; logic [15:0] res; logic ovf, err, ba; logic [1:0] id;
        run_op(0, OP_GT, 8'h7F, 8'h80, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({res, ovf, err} !== {16'h0001, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL gt_7f_80: got res=%h ovf=%b err=%b, want 0001 0 0", res, ovf, err);
        end
        run_op(0, OP_GT, 8'h00, 8'hFF, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (res !== 16'h0001) begin
            n_fail++; $display("FAIL gt_00_ff: got %h, want 0001", res);
        end
        run_op(0, OP_GT, 8'hFF, 8'h00, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (res !== 16'h0000) begin
            n_fail++; $display("FAIL gt_ff_00: got %h, want 0000", res);
        end
        run_op(0, OP_EQ, 8'hFF, 8'hFF, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (res !== 16'h0001) begin
            n_fail++; $display("FAIL eq_ff_ff: got %h, want 0001", res);
        end
        run_op(0, OP_EQ, 8'h01, 8'h02, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if (res !== 16'h0000) begin
            n_fail++; $display("FAIL eq_01_02: got %h, want 0000", res);
        end
        run_op(0, 3'd6, 8'h12, 8'h34, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({res, ovf, err, lat} !== {16'h0000, 1'b0, 1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL illegal_op6: got res=%h ovf=%b err=%b lat=%0d, want 0000 0 1 2",
                     res, ovf, err, lat);
        end
        run_op(0, OP_ADD, 8'h01, 8'h01, rdy, lat, res, ovf, err, id, ba);
        n_checks++;
        if ({res, err} !== {16'h0002, 1'b0}) begin
            n_fail++; $display("FAIL err_clears: got res=%h err=%b, want 0002 0", res, err);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        int exp_id;
        logic saw_grant_busy;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 8'(i + 1), 8'h10);
        req_valid = 3'b111;
        #1;
        for (int n = 0; n < 6; n++) begin
            exp_id = n % 3;
            k = 0;
            while (req_ready == 3'b000 && k < 10) begin
                @(negedge clk); #1; k++;
            end
            n_checks++;
            if (req_ready !== (3'b001 << exp_id)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b, want %b", n, req_ready, 3'b001 << exp_id);
            end
            if (n == 5) rsp_ready = 1'b0;
            k = 0;
            saw_grant_busy = 1'b0;
            @(negedge clk); #1;
            while (!rsp_valid && k < 10) begin
                if (req_ready !== 3'b000) saw_grant_busy = 1'b1;
                @(negedge clk); #1; k++;
            end
            if (req_ready !== 3'b000) saw_grant_busy = 1'b1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, saw_grant_busy} !==
                {1'b1, 2'(exp_id), 16'(exp_id + 17), 1'b0}) begin
                n_fail++;
                $display("FAIL rr_rsp_%0d: got valid=%b id=%0d res=%h busy_grant=%b, want 1 %0d %h 0",
                         n, rsp_valid, rsp_id, rsp_result, saw_grant_busy, exp_id, 16'(exp_id + 17));
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_result, req_ready, busy} !==
                {1'b1, 2'd2, 16'h0013, 3'b000, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_%0d: got valid=%b id=%0d res=%h ready=%b busy=%b, want 1 2 0013 000 1",
                         c, rsp_valid, rsp_id, rsp_result, req_ready, busy);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL stall_release: got valid=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_op;
        int k;
        logic saw_valid;
        apply_reset();
        // Reset while a response is being held.
        rsp_ready = 1'b0;
        set_req(0, OP_ADD, 8'h11, 8'h22);
        req_valid = 3'b001;
        @(negedge clk);
        req_valid = '0;
        k = 0;
        while (!rsp_valid && k < 10) begin
            @(negedge clk); k++;
        end
        n_checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, 16'h0033}) begin
            n_fail++;
            $display("FAIL resp_hold: got valid=%b res=%h, want 1 0033", rsp_valid, rsp_result);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_result, rsp_id, rsp_ovf, rsp_err} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_in_resp: got valid=%b busy=%b res=%h id=%0d, want 0 0 0000 0",
                     rsp_valid, busy, rsp_result, rsp_id);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        // Reset while a mul from requester 1 is executing.
        @(negedge clk);
        set_req(1, OP_MUL, 8'h40, 8'h40);
        req_valid = 3'b010;
        @(negedge clk);
        req_valid = '0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mul_exec_busy: got %b, want 1", busy);
        end
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid || busy) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_mul: got response/busy after reset, want none");
        end
        set_req(0, OP_SUB, 8'h09, 8'h04);
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL post_reset_grant: got %b, want 001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        k = 0;
        while (!rsp_valid && k < 10) begin
            @(negedge clk); k++;
        end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd0, 16'h0005}) begin
            n_fail++;
            $display("FAIL post_reset_rsp: got valid=%b id=%0d res=%h, want 1 0 0005",
                     rsp_valid, rsp_id, rsp_result);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_sub_ovf();
        test_mul();
        test_compare();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
